// File: rtl/div_controller.sv
// Control FSM for the 5-bit restoring divider: operand load, five shift/subtract steps, two-phase readout.
// Optional DIV_ERR_CHECK_EN adds the divide-by-zero / overflow CHECK stage and the error states.
module div_controller (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic zero_flag,
  input  logic overflow_flag,
  input  logic MSB,
  input  logic Co,
  output logic selA,
  output logic selB,
  output logic ldA,
  output logic ldB,
  output logic ldQ,
  output logic shL,
  output logic sel_out,
  output logic selTRI,
  output logic init_counter,
  output logic inc_counter,
  output logic ready,
  output logic q_valid,
  output logic r_valid,
  output logic err_div0,
  output logic err_ovf
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    LOAD_Q = 4'd1,
    LOAD_A = 4'd2,
    LOAD_B = 4'd3,
    CHECK  = 4'd4,
    SHIFT  = 4'd5,
    SUB    = 4'd6,
    OUT_Q  = 4'd7,
    OUT_R  = 4'd8,
    ERR_Z  = 4'd9,
    ERR_O  = 4'd10
  } state_t;

  state_t state_q, state_d;

  logic lda_q, ldb_q, sub_q;
  logic lda_d, ldb_d, sub_d;
  logic ldq_d, shl_d, sel_out_d, tri_d, init_d, inc_d, ready_d, qv_d, rv_d, ez_d, eo_d;
  logic sub_ld_c;

`ifndef DIV_ERR_CHECK_EN
  // Datapath flags only matter when the check stage is built in.
  logic unused_flags;
  assign unused_flags = zero_flag ^ overflow_flag;
`endif

  // Next state, plus Moore outputs decoded from the next state so they register in step with it.
  always_comb begin
    state_d   = state_q;
    ldq_d     = 1'b0;
    lda_d     = 1'b0;
    ldb_d     = 1'b0;
    sub_d     = 1'b0;
    shl_d     = 1'b0;
    sel_out_d = 1'b0;
    tri_d     = 1'b0;
    init_d    = 1'b0;
    inc_d     = 1'b0;
    ready_d   = 1'b0;
    qv_d      = 1'b0;
    rv_d      = 1'b0;
    ez_d      = 1'b0;
    eo_d      = 1'b0;

    case (state_q)
      IDLE:   if (start) state_d = LOAD_Q;
      LOAD_Q: state_d = LOAD_A;
      LOAD_A: state_d = LOAD_B;
`ifdef DIV_ERR_CHECK_EN
      LOAD_B: state_d = CHECK;
      CHECK: begin
        if (zero_flag)          state_d = ERR_Z;
        else if (overflow_flag) state_d = ERR_O;
        else                    state_d = SHIFT;
      end
      ERR_Z:  state_d = IDLE;
      ERR_O:  state_d = IDLE;
`else
      LOAD_B: state_d = SHIFT;
`endif
      SHIFT:  state_d = SUB;
      SUB:    state_d = Co ? OUT_Q : SHIFT;
      OUT_Q:  state_d = OUT_R;
      OUT_R:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    case (state_d)
      IDLE:   ready_d = 1'b1;
      LOAD_Q: ldq_d   = 1'b1;
      LOAD_A: lda_d   = 1'b1;
      LOAD_B: begin
        ldb_d  = 1'b1;
        init_d = 1'b1;
      end
      SHIFT: begin
        shl_d = 1'b1;
        inc_d = 1'b1;
      end
      SUB:   sub_d = 1'b1;
      OUT_Q: begin
        tri_d     = 1'b1;
        sel_out_d = 1'b1;
        qv_d      = 1'b1;
      end
      OUT_R: begin
        tri_d = 1'b1;
        rv_d  = 1'b1;
      end
      ERR_Z:  ez_d = 1'b1;
      ERR_O:  eo_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      lda_q        <= 1'b0;
      ldb_q        <= 1'b0;
      sub_q        <= 1'b0;
      ldQ          <= 1'b0;
      shL          <= 1'b0;
      sel_out      <= 1'b0;
      selTRI       <= 1'b0;
      init_counter <= 1'b0;
      inc_counter  <= 1'b0;
      ready        <= 1'b1;
      q_valid      <= 1'b0;
      r_valid      <= 1'b0;
      err_div0     <= 1'b0;
      err_ovf      <= 1'b0;
    end else begin
      state_q      <= state_d;
      lda_q        <= lda_d;
      ldb_q        <= ldb_d;
      sub_q        <= sub_d;
      ldQ          <= ldq_d;
      shL          <= shl_d;
      sel_out      <= sel_out_d;
      selTRI       <= tri_d;
      init_counter <= init_d;
      inc_counter  <= inc_d;
      ready        <= ready_d;
      q_valid      <= qv_d;
      r_valid      <= rv_d;
      err_div0     <= ez_d;
      err_ovf      <= eo_d;
    end
  end

  // SUB accepts the difference only when it is non-negative; MSB is the live sign from the datapath.
  assign sub_ld_c = sub_q & ~MSB;
  assign ldA  = lda_q | sub_ld_c;
  assign ldB  = ldb_q | sub_ld_c;
  assign selA = sub_ld_c;
  assign selB = sub_ld_c;

endmodule

// File: doc/div_controller.md
# div_controller

Control unit for the 5-bit restoring divider datapath. Sequences operand loading from the shared 5-bit input bus, the five shift/subtract/restore iterations, and the two-phase result readout over the tri-state output bus. Checks divide-by-zero and quotient overflow before iterating. Sits beside the datapath in the divider top level; the host sees only the start/ready/valid/error handshake.

## Interface
- No parameters; iteration count is fixed by the datapath counter (5).
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  host request; sampled only in IDLE
- zero_flag  in  1  datapath: divisor register is zero
- overflow_flag  in  1  datapath: A ≥ Q (quotient would exceed 5 bits)
- MSB  in  1  datapath: sign of A−Q (1 = negative, restore)
- Co  in  1  datapath counter terminal count (high after 5th inc_counter)
- selA, selB  out  1  0 = bus_in, 1 = subtract result / {B[4:1],1}
- ldA, ldB, ldQ  out  1  register parallel-load enables
- shL  out  1  shift A:B left one bit
- sel_out  out  1  0 = remainder (A[4:0]), 1 = quotient (B)
- selTRI  out  1  drive output bus
- init_counter, inc_counter  out  1  iteration counter clear / increment
- ready  out  1  controller in IDLE, start accepted
- q_valid, r_valid  out  1  quotient / remainder on output bus this cycle
- err_div0, err_ovf  out  1  one-cycle error pulse

## Operation
- Operands: divisor, dividend high 5 bits, dividend low 5 bits, presented on bus_in in that order, one per cycle, starting the cycle after start is sampled.
- States and Moore outputs (unlisted outputs 0):
  - IDLE: ready=1. start=1 → LOAD_Q.
  - LOAD_Q: ldQ=1. → LOAD_A.
  - LOAD_A: ldA=1, selA=0. → LOAD_B.
  - LOAD_B: ldB=1, selB=0, init_counter=1. → CHECK.
  - CHECK: no outputs. zero_flag=1 → ERR_Z; else overflow_flag=1 → ERR_O; else → SHIFT. zero has priority.
  - SHIFT: shL=1, inc_counter=1. → SUB.
  - SUB: if MSB=0 then ldA=1, selA=1, ldB=1, selB=1 (accept difference, set quotient bit); if MSB=1 no load (restore). Co=1 → OUT_Q, else → SHIFT.
  - OUT_Q: selTRI=1, sel_out=1, q_valid=1. → OUT_R.
  - OUT_R: selTRI=1, sel_out=0, r_valid=1. → IDLE.
  - ERR_Z: err_div0=1. → IDLE. ERR_O: err_ovf=1. → IDLE.
- MSB is a Mealy input in SUB only; all other outputs are pure state decode.
- ldA/ldB and shL never asserted in the same cycle; selTRI asserted only in OUT_Q/OUT_R.
- start outside IDLE ignored; no queuing.

## Timing
- start sampled at cycle 0 → LOAD_Q cycle 1, LOAD_A 2, LOAD_B 3, CHECK 4, SHIFT/SUB pairs 5–14, OUT_Q 15, OUT_R 16, ready=1 at 17.
- Error path: error pulse at cycle 5, ready at 6.
- Back-to-back: start high in cycle 17 begins next operation; minimum period 17 cycles.
- Reset (rst=0, any time, incl. mid-iteration or readout): state → IDLE asynchronously; all outputs 0 except ready=1; selTRI released immediately.

## Configuration
- DIV_ERR_CHECK_EN defined: CHECK and ERR states present as above.
- Undefined: LOAD_B → SHIFT directly (latency one cycle shorter, ready at 16); zero_flag/overflow_flag ignored; err_div0, err_ovf tied 0; results for invalid operands are don't-care.

## Test plan
- Reset mid-SUB (rst low cycle 8) → all controls 0, ready=1 during and after reset; next start runs full sequence.
- 100/7 (bus: 7, 3, 4) → q_valid cycle 15 bus=14, r_valid cycle 16 bus=2, ready cycle 17.
- 991/31 (bus: 31, 30, 31) → quotient 31, remainder 30; exactly 5 SHIFT pulses, 5 SUB loads (MSB=0 every iteration).
- Divisor 0 (bus: 0, 3, 4) → err_div0 one cycle at cycle 5, no shL/selTRI, ready at 6; with macro undefined → err_div0 stays 0.
- Overflow 256/5 (bus: 5, 8, 0) → err_ovf pulse cycle 5, err_div0=0.
- start held high continuously → operations back-to-back every 17 cycles; start pulses during busy have no effect.
